updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised successor to the team's free-running 8-bit up counter.
- Adds count direction, enable, synchronous load and clear, a programmable modulus, wrap or saturate mode, an enable prescaler, a terminal-count pulse and a sticky overflow flag.
- Serves as the general counter/timer primitive for workshop designs: event counters, BCD digits and timebases.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX, 255: terminal value; count range is 0..MAX; must satisfy MAX <= 2^WIDTH-1.
- SAT, 0: boundary mode; 0 = wrap, 1 = saturate at boundary.
- PRESCALE, 1: number of enabled clk cycles per count step; legal range 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear, active-high.
- load  in  1  synchronous load, active-high.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable, active-high.
- up_dn  in  1  direction; 1 = up, 0 = down.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky boundary-crossing flag.

Behaviour:
- Reset (rst low, asynchronous): count=0, tc=0, ovf=0, prescaler=0. All outputs are held while rst is low. The first update happens on the first clk rising edge after rst deasserts.
- Priority per clk edge: clr > load > step > hold.
- clr: count=0, prescaler=0, ovf=0, tc=0.
- load: count=min(load_val, MAX); prescaler=0; tc=0; ovf unchanged.
- Prescaler: increments on every edge with en=1 and no clr/load.
  - A step fires on the edge where prescaler==PRESCALE-1 and en=1; the prescaler then returns to 0.
  - en=0 freezes the prescaler and the count.
  - With PRESCALE=1 every enabled edge is a step, so count changes on the edge where en is sampled high (latency 1).
- Step, up_dn=1:
  - count<MAX: count+1.
  - count==MAX: becomes 0 when SAT=0; stays at MAX when SAT=1.
- Step, up_dn=0:
  - count>0: count-1.
  - count==0: becomes MAX when SAT=0; stays at 0 when SAT=1.
- Boundary event = a step taken with count==MAX going up, or count==0 going down.
  - On a boundary event, tc=1 for exactly the next cycle (registered on the same edge that updates count). Otherwise tc=0.
  - A boundary event sets ovf=1. ovf stays set until clr or rst.
- SAT=1 with en held at the boundary: tc pulses once per step, every step that hits the boundary.
- Arithmetic: no intermediate result exceeds WIDTH bits. Wrap is to 0 or MAX, not modulo 2^WIDTH unless MAX=2^WIDTH-1.
- Direction change takes effect on the next step and leaves the prescaler untouched.
- Simultaneous clr and load: clr wins. Simultaneous load and en: load wins; the step is discarded.
- rst asserted mid-prescale: the prescaler clears immediately.

Test Plan:
- Reset and defaults: rst low 2 cycles, then high; en=1, up_dn=1 for 260 cycles.
  - count 0,1,...,255,0,1,...
  - tc high only in the cycle count shows 0 after 255; ovf=1 from then on.
- Modulus and down wrap, MAX=9, SAT=0: load 3, up_dn=0, en=1.
  - count 3,2,1,0,9,8.
  - tc=1 only in the cycle count=9.
- Saturation, MAX=9, SAT=1: load 8, up 3 steps.
  - count 8,9,9,9; tc pulses twice; ovf=1.
  - Then down from 0: count holds at 0.
- Prescale, PRESCALE=4, en=1: count advances once every 4 edges (0→1 on the 4th edge).
  - Drop en for 3 cycles mid-period: the step is delayed by exactly 3 cycles.
- Priority: assert clr and load (load_val=5) with en on the same edge → count=0, ovf=0.
  - Then load_val=200 with MAX=9 → count=9.
- Async reset mid-count: pull rst low between edges at count=7 → count=0 immediately, before the next edge; tc=0, ovf=0.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, wrap/saturate, enable prescaler,
// terminal-count pulse and sticky overflow; general counter/timer primitive.
module updown_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter int unsigned SAT      = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam bit               SAT_MODE = (SAT != 0);

    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;
    logic             step_c;
    logic             at_top_c;
    logic             at_bot_c;

    assign step_c   = en && (pre_q == PRE_LAST);
    assign at_top_c = (count == MAX_V);
    assign at_bot_c = (count == ZERO_V);

    // Next-state: clr > load > step > prescale advance > hold.
    always_comb begin
        count_d = count;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf;
        if (clr) begin
            count_d = ZERO_V;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
            pre_d   = '0;
        end else if (en) begin
            if (step_c) begin
                pre_d = '0;
                if (up_dn) begin
                    if (at_top_c) begin
                        count_d = SAT_MODE ? MAX_V : ZERO_V;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count + ONE_V;
                    end
                end else begin
                    if (at_bot_c) begin
                        count_d = SAT_MODE ? ZERO_V : MAX_V;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count - ONE_V;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= ZERO_V;
            pre_q <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            pre_q <= pre_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: four instances cover default,
// modulus-9 wrap, modulus-9 saturate and prescale-4 configurations.
module tb_updown_counter_param;

    logic clk;
    logic rst;

    logic       clr0, load0, en0, ud0;
    logic [7:0] lv0, c0;
    logic       tc0, ovf0;

    logic       clr1, load1, en1, ud1;
    logic [7:0] lv1, c1;
    logic       tc1, ovf1;

    logic       clr2, load2, en2, ud2;
    logic [7:0] lv2, c2;
    logic       tc2, ovf2;

    logic       clr3, load3, en3, ud3;
    logic [7:0] lv3, c3;
    logic       tc3, ovf3;

    int n_tests = 0;
    int n_fail  = 0;

    updown_counter_param #(.WIDTH(8), .MAX(255), .SAT(0), .PRESCALE(1)) u_def (
        .clk(clk), .rst(rst), .clr(clr0), .load(load0), .load_val(lv0),
        .en(en0), .up_dn(ud0), .count(c0), .tc(tc0), .ovf(ovf0));

    updown_counter_param #(.WIDTH(8), .MAX(9), .SAT(0), .PRESCALE(1)) u_wrap9 (
        .clk(clk), .rst(rst), .clr(clr1), .load(load1), .load_val(lv1),
        .en(en1), .up_dn(ud1), .count(c1), .tc(tc1), .ovf(ovf1));

    updown_counter_param #(.WIDTH(8), .MAX(9), .SAT(1), .PRESCALE(1)) u_sat9 (
        .clk(clk), .rst(rst), .clr(clr2), .load(load2), .load_val(lv2),
        .en(en2), .up_dn(ud2), .count(c2), .tc(tc2), .ovf(ovf2));

    updown_counter_param #(.WIDTH(8), .MAX(255), .SAT(0), .PRESCALE(4)) u_pre4 (
        .clk(clk), .rst(rst), .clr(clr3), .load(load3), .load_val(lv3),
        .en(en3), .up_dn(ud3), .count(c3), .tc(tc3), .ovf(ovf3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e_cnt[5];
        int e_tc[5];

        rst = 1'b0;
        {clr0, load0, en0, ud0, lv0} = '0;
        {clr1, load1, en1, ud1, lv1} = '0;
        {clr2, load2, en2, ud2, lv2} = '0;
        {clr3, load3, en3, ud3, lv3} = '0;

        // Reset held for two edges
        tick();
        tick();
        check("rst_count", 32'(c0), 0);
        check("rst_tc",    32'(tc0), 0);
        check("rst_ovf",   32'(ovf0), 0);
        check("rst_pre_count", 32'(c3), 0);

        // Free-running up count through the 255->0 wrap
        rst = 1'b1;
        en0 = 1'b1;
        ud0 = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            check("def_count", 32'(c0), i % 256);
            check("def_tc",    32'(tc0), (i == 256) ? 1 : 0);
            check("def_ovf",   32'(ovf0), (i >= 256) ? 1 : 0);
        end
        en0 = 1'b0;

        // Modulus 9, wrap, counting down from 3
        load1 = 1'b1;
        lv1   = 8'd3;
        tick();
        check("wrap_load", 32'(c1), 3);
        load1 = 1'b0;
        ud1   = 1'b0;
        en1   = 1'b1;
        e_cnt = '{2, 1, 0, 9, 8};
        e_tc  = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wrap_count", 32'(c1), e_cnt[i]);
            check("wrap_tc",    32'(tc1), e_tc[i]);
        end
        check("wrap_ovf", 32'(ovf1), 1);

        // Modulus 9, saturate going up from 8
        load2 = 1'b1;
        lv2   = 8'd8;
        tick();
        check("sat_load", 32'(c2), 8);
        load2 = 1'b0;
        ud2   = 1'b1;
        en2   = 1'b1;
        e_cnt = '{9, 9, 9, 0, 0};
        e_tc  = '{0, 1, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_up_count", 32'(c2), e_cnt[i]);
            check("sat_up_tc",    32'(tc2), e_tc[i]);
        end
        check("sat_ovf", 32'(ovf2), 1);
        load2 = 1'b1;
        lv2   = 8'd0;
        tick();
        check("sat_load0", 32'(c2), 0);
        check("sat_load_tc", 32'(tc2), 0);
        load2 = 1'b0;
        ud2   = 1'b0;
        tick();
        check("sat_dn_count", 32'(c2), 0);
        check("sat_dn_tc",    32'(tc2), 1);
        tick();
        check("sat_dn_hold", 32'(c2), 0);
        en2 = 1'b0;

        // Prescale 4: first step on the 4th enabled edge
        en3 = 1'b1;
        ud3 = 1'b1;
        e_cnt = '{0, 0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pre_count", 32'(c3), e_cnt[i]);
        end
        tick();
        tick();
        check("pre_mid", 32'(c3), 1);
        en3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_frozen", 32'(c3), 1);
        end
        en3 = 1'b1;
        tick();
        check("pre_delayed", 32'(c3), 1);
        tick();
        check("pre_step2", 32'(c3), 2);
        tick();
        en3 = 1'b0;

        // Priority: clr beats load beats step
        clr1  = 1'b1;
        load1 = 1'b1;
        lv1   = 8'd5;
        en1   = 1'b1;
        tick();
        check("prio_clr_count", 32'(c1), 0);
        check("prio_clr_ovf",   32'(ovf1), 0);
        check("prio_clr_tc",    32'(tc1), 0);
        clr1 = 1'b0;
        lv1  = 8'd200;
        tick();
        check("prio_load_clamp", 32'(c1), 9);
        check("prio_load_ovf",   32'(ovf1), 0);
        load1 = 1'b0;
        en1   = 1'b0;

        // Async reset between edges at count 7
        load0 = 1'b1;
        lv0   = 8'd7;
        tick();
        load0 = 1'b0;
        check("ar_pre_count", 32'(c0), 7);
        check("ar_pre_ovf",   32'(ovf0), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_count", 32'(c0), 0);
        check("ar_tc",    32'(tc0), 0);
        check("ar_ovf",   32'(ovf0), 0);
        check("ar_pre4_count", 32'(c3), 0);
        tick();
        rst = 1'b1;

        // Prescaler restarts from zero after reset
        en3 = 1'b1;
        tick();
        tick();
        tick();
        check("ar_pre_restart3", 32'(c3), 0);
        tick();
        check("ar_pre_restart4", 32'(c3), 1);
        en3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
